// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by the pipeline hazard/forwarding block and its
// MDU scoreboard.
//   FWD_*        3-bit operand-select codes driven on fwda/fwdb
//   RW_DEF       default register-address width
//   MDU_LAT_DEF  default MDU issue-to-writeback latency in cycles
//   CNT_W        width of the scoreboard countdown (holds up to 15)
package pipe_pkg;

  localparam int RW_DEF      = 5;
  localparam int MDU_LAT_DEF = 4;
  localparam int CNT_W       = 4;

  localparam logic [2:0] FWD_RF   = 3'b000;
  localparam logic [2:0] FWD_EALU = 3'b001;
  localparam logic [2:0] FWD_MALU = 3'b010;
  localparam logic [2:0] FWD_MMEM = 3'b011;
  localparam logic [2:0] FWD_W    = 3'b100;
  localparam logic [2:0] FWD_MDU  = 3'b101;

endpackage

// File: rtl/pipe_hazard_unit_mdu_scoreboard.sv
// mdu_scoreboard: tracks the single outstanding multiply/divide write.
//   clock, resetn     pipeline clock, synchronous active-low reset
//   i_issue           an MDU op leaves D this cycle (already qualified by ~stall)
//   i_issue_rn        destination of the issuing op
//   o_busy            a write is pending
//   o_wb              one-cycle pulse in the cycle the result is written back
//   o_rn              pending destination register
module mdu_scoreboard
  import pipe_pkg::*;
#(
  parameter int RW      = RW_DEF,
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_issue,
  input  logic [RW-1:0] i_issue_rn,
  output logic          o_busy,
  output logic          o_wb,
  output logic [RW-1:0] o_rn
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LAT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [RW-1:0]    r_rn;

  // A new issue always wins: it can only be accepted while idle or in the
  // write-back cycle, so it either starts or seamlessly chains the unit.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_rn   <= '0;
    end else if (i_issue) begin
      r_cnt  <= LAT;
      r_busy <= 1'b1;
      r_rn   <= i_issue_rn;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_busy <= (r_cnt != CNT_W'(1));
    end
  end

  // Reset is synchronous, so state may still be stale while resetn is low;
  // gate the outputs so the pipeline sees an idle unit throughout reset.
  assign o_busy = r_busy & resetn;
  assign o_wb   = (r_cnt == CNT_W'(1)) & resetn;
  assign o_rn   = r_rn & {RW{resetn}};

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: stall/bubble and operand-forwarding control for the
// 5-stage pipeline, including a W-stage source and a multi-cycle MDU source.
//   clock, resetn                 clock, synchronous active-low reset
//   rs, rt, urs, urt              D-stage sources and their use flags
//   d_wreg, d_mdu, d_rn           D-stage write flags and destination
//   ewreg, em2reg, ern            E-stage write/load flags and destination
//   mwreg, mm2reg, mrn            M-stage write/load flags and destination
//   wwreg, wrn                    W-stage write flag and destination
//   wpcir                         1 = PC and F/D may advance
//   bubble                        1 = E register loads a no-op
//   fwda, fwdb                    operand selects (pipe_pkg FWD_* codes)
//   mdu_busy, mdu_wb, mdu_rn      MDU scoreboard state
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int RW      = RW_DEF,
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic          urs,
  input  logic          urt,
  input  logic          d_wreg,
  input  logic          d_mdu,
  input  logic [RW-1:0] d_rn,
  input  logic          ewreg,
  input  logic          em2reg,
  input  logic [RW-1:0] ern,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic [RW-1:0] mrn,
  input  logic          wwreg,
  input  logic [RW-1:0] wrn,
  output logic          wpcir,
  output logic          bubble,
  output logic [2:0]    fwda,
  output logic [2:0]    fwdb,
  output logic          mdu_busy,
  output logic          mdu_wb,
  output logic [RW-1:0] mdu_rn
);

  logic          w_busy;
  logic          w_wb;
  logic [RW-1:0] w_mrn;
  logic          w_pend;
  logic          w_load_use;
  logic          w_raw_mdu;
  logic          w_struct;
  logic          w_waw;
  logic          w_stall;
  logic          w_issue;

  function automatic logic [2:0] fwd_sel(
    input logic [RW-1:0] src,
    input logic          e_w,
    input logic [RW-1:0] e_rn,
    input logic          m_w,
    input logic          m_ld,
    input logic [RW-1:0] m_rn,
    input logic          w_w,
    input logic [RW-1:0] w_rn,
    input logic          x_wb,
    input logic [RW-1:0] x_rn
  );
    logic [2:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (e_w && e_rn == src)      sel = FWD_EALU;
      else if (m_w && m_rn == src) sel = m_ld ? FWD_MMEM : FWD_MALU;
      else if (w_w && w_rn == src) sel = FWD_W;
      else if (x_wb && x_rn == src) sel = FWD_MDU;
    end
    return sel;
  endfunction

  // Pending MDU write that is not yet resolvable by forwarding.
  assign w_pend = w_busy & ~w_wb;

  assign w_load_use = ewreg & em2reg & (ern != '0) &
                      ((urs & (ern == rs)) | (urt & (ern == rt)));
  assign w_raw_mdu  = w_pend & (w_mrn != '0) &
                      ((urs & (w_mrn == rs)) | (urt & (w_mrn == rt)));
  assign w_struct   = d_mdu & w_pend;
  assign w_waw      = (d_wreg | d_mdu) & w_pend & (d_rn == w_mrn) & (d_rn != '0);

  assign w_stall = resetn & (w_load_use | w_raw_mdu | w_struct | w_waw);
  assign w_issue = d_mdu & ~w_stall;

  assign wpcir  = ~w_stall;
  assign bubble = w_stall;

  always_comb begin
    fwda = FWD_RF;
    fwdb = FWD_RF;
    if (resetn) begin
      fwda = fwd_sel(rs, ewreg, ern, mwreg, mm2reg, mrn, wwreg, wrn, w_wb, w_mrn);
      fwdb = fwd_sel(rt, ewreg, ern, mwreg, mm2reg, mrn, wwreg, wrn, w_wb, w_mrn);
    end
  end

  mdu_scoreboard #(
    .RW      (RW),
    .MDU_LAT (MDU_LAT)
  ) u_sb (
    .clock      (clock),
    .resetn     (resetn),
    .i_issue    (w_issue),
    .i_issue_rn (d_rn),
    .o_busy     (w_busy),
    .o_wb       (w_wb),
    .o_rn       (w_mrn)
  );

  assign mdu_busy = w_busy;
  assign mdu_wb   = w_wb;
  assign mdu_rn   = w_mrn;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int RW = 5;

  logic          clock = 1'b0;
  logic          resetn;
  logic [RW-1:0] rs, rt, d_rn, ern, mrn, wrn;
  logic          urs, urt, d_wreg, d_mdu, ewreg, em2reg, mwreg, mm2reg, wwreg;
  logic          wpcir, bubble, mdu_busy, mdu_wb;
  logic [2:0]    fwda, fwdb;
  logic [RW-1:0] mdu_rn;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_unit #(.RW(RW), .MDU_LAT(4)) dut (
    .clock(clock), .resetn(resetn),
    .rs(rs), .rt(rt), .urs(urs), .urt(urt),
    .d_wreg(d_wreg), .d_mdu(d_mdu), .d_rn(d_rn),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .wwreg(wwreg), .wrn(wrn),
    .wpcir(wpcir), .bubble(bubble), .fwda(fwda), .fwdb(fwdb),
    .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_rn(mdu_rn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs = '0; rt = '0; urs = 0; urt = 0; d_wreg = 0; d_mdu = 0; d_rn = '0;
    ewreg = 0; em2reg = 0; ern = '0; mwreg = 0; mm2reg = 0; mrn = '0;
    wwreg = 0; wrn = '0;
  endtask

  // Advance to just after the next rising edge and clear all D/E/M/W inputs.
  task automatic nxt();
    @(posedge clock);
    #1;
    clr();
  endtask

  initial begin
    // Reset: hazardous inputs must be masked while resetn is low.
    resetn = 0;
    clr();
    ewreg = 1; em2reg = 1; ern = 3; rs = 3; urs = 1; d_mdu = 1; d_rn = 3;
    #2;
    chk("rst_wpcir", 8'(wpcir), 8'd1);
    chk("rst_bubble", 8'(bubble), 8'd0);
    chk("rst_fwda", 8'(fwda), 8'd0);
    chk("rst_busy", 8'(mdu_busy), 8'd0);
    chk("rst_wb", 8'(mdu_wb), 8'd0);
    chk("rst_rn", 8'(mdu_rn), 8'd0);
    nxt(); nxt();
    resetn = 1;
    #1;
    chk("post_rst_busy", 8'(mdu_busy), 8'd0);

    // 1. Load-use: one-cycle stall, then M-memory forward.
    nxt(); ewreg = 1; em2reg = 1; ern = 3; rs = 3; urs = 1; d_wreg = 1; d_rn = 4; #1;
    chk("lu_wpcir", 8'(wpcir), 8'd0);
    chk("lu_bubble", 8'(bubble), 8'd1);
    chk("lu_fwda_e", 8'(fwda), 8'd1);
    nxt(); mwreg = 1; mm2reg = 1; mrn = 3; rs = 3; urs = 1; d_wreg = 1; d_rn = 4; #1;
    chk("lu_after_wpcir", 8'(wpcir), 8'd1);
    chk("lu_after_bubble", 8'(bubble), 8'd0);
    chk("lu_fwda_mmem", 8'(fwda), 8'd3);
    nxt(); ewreg = 1; em2reg = 1; ern = 3; rt = 3; urt = 1; #1;
    chk("lu_rt_wpcir", 8'(wpcir), 8'd0);
    nxt(); ewreg = 1; em2reg = 1; ern = 3; rt = 3; urt = 0; #1;
    chk("lu_unused_wpcir", 8'(wpcir), 8'd1);
    chk("lu_unused_fwdb", 8'(fwdb), 8'd1);

    // 2. Forwarding priority.
    nxt(); ewreg = 1; ern = 5; wwreg = 1; wrn = 5; rs = 5; urs = 1; #1;
    chk("fw_e_over_w", 8'(fwda), 8'd1);
    chk("fw_alu_nostall", 8'(wpcir), 8'd1);
    nxt(); wwreg = 1; wrn = 5; rs = 5; urs = 1; #1;
    chk("fw_w", 8'(fwda), 8'd4);
    nxt(); ewreg = 1; ern = 0; rs = 0; urs = 1; #1;
    chk("fw_r0", 8'(fwda), 8'd0);
    nxt(); mwreg = 1; mrn = 6; wwreg = 1; wrn = 6; rt = 6; urt = 1; #1;
    chk("fw_malu_b", 8'(fwdb), 8'd2);
    nxt(); ewreg = 0; ern = 6; rt = 6; urt = 1; #1;
    chk("fw_flag_off", 8'(fwdb), 8'd0);

    // 3. MDU RAW: stall t+1..t+3, forward at t+4.
    nxt(); d_mdu = 1; d_rn = 7; #1;
    chk("mdu_issue_wpcir", 8'(wpcir), 8'd1);
    chk("mdu_issue_busy", 8'(mdu_busy), 8'd0);
    for (int k = 1; k <= 3; k++) begin
      nxt(); rs = 7; urs = 1; #1;
      chk($sformatf("raw_busy_%0d", k), 8'(mdu_busy), 8'd1);
      chk($sformatf("raw_wb_%0d", k), 8'(mdu_wb), 8'd0);
      chk($sformatf("raw_wpcir_%0d", k), 8'(wpcir), 8'd0);
      chk($sformatf("raw_rn_%0d", k), 8'(mdu_rn), 8'd7);
    end
    nxt(); rs = 7; urs = 1; #1;
    chk("raw_wb_busy", 8'(mdu_busy), 8'd1);
    chk("raw_wb_pulse", 8'(mdu_wb), 8'd1);
    chk("raw_wb_wpcir", 8'(wpcir), 8'd1);
    chk("raw_wb_fwda", 8'(fwda), 8'd5);
    nxt(); rs = 7; urs = 1; #1;
    chk("raw_done_busy", 8'(mdu_busy), 8'd0);
    chk("raw_done_wb", 8'(mdu_wb), 8'd0);
    chk("raw_done_fwda", 8'(fwda), 8'd0);

    // 4. Structural: second MDU op waits for the write-back cycle.
    nxt(); d_mdu = 1; d_rn = 7; #1;
    for (int k = 1; k <= 3; k++) begin
      nxt(); d_mdu = 1; d_rn = 9; #1;
      chk($sformatf("st_wpcir_%0d", k), 8'(wpcir), 8'd0);
    end
    nxt(); d_mdu = 1; d_rn = 9; #1;
    chk("st_wb", 8'(mdu_wb), 8'd1);
    chk("st_accept", 8'(wpcir), 8'd1);
    nxt(); #1;
    chk("st_busy_nogap", 8'(mdu_busy), 8'd1);
    chk("st_new_rn", 8'(mdu_rn), 8'd9);
    chk("st_new_wb", 8'(mdu_wb), 8'd0);
    nxt(); nxt();
    nxt(); rt = 9; urt = 1; #1;
    chk("st2_wb", 8'(mdu_wb), 8'd1);
    chk("st2_fwdb", 8'(fwdb), 8'd5);

    // 5. WAW against the pending destination.
    nxt(); d_mdu = 1; d_rn = 7; #1;
    chk("waw_issue_busy_clear", 8'(mdu_busy), 8'd0);
    nxt(); d_wreg = 1; d_rn = 8; #1;
    chk("waw_other_rn", 8'(wpcir), 8'd1);
    nxt(); d_wreg = 1; d_rn = 7; #1;
    chk("waw_stall_a", 8'(wpcir), 8'd0);
    nxt(); d_wreg = 1; d_rn = 7; #1;
    chk("waw_stall_b", 8'(wpcir), 8'd0);
    nxt(); d_wreg = 1; d_rn = 7; #1;
    chk("waw_wb_release", 8'(wpcir), 8'd1);
    chk("waw_wb_pulse", 8'(mdu_wb), 8'd1);

    // MDU op to r0: occupies the unit but never hazards or forwards.
    nxt(); d_mdu = 1; d_rn = 0; #1;
    nxt(); rs = 0; urs = 1; d_wreg = 1; d_rn = 0; #1;
    chk("r0_busy", 8'(mdu_busy), 8'd1);
    chk("r0_no_stall", 8'(wpcir), 8'd1);
    nxt(); d_mdu = 1; d_rn = 0; #1;
    chk("r0_struct", 8'(wpcir), 8'd0);
    nxt();
    nxt(); rs = 0; urs = 1; #1;
    chk("r0_wb", 8'(mdu_wb), 8'd1);
    chk("r0_no_fwd", 8'(fwda), 8'd0);

    // 6. Reset mid-operation drops the pending write.
    nxt(); d_mdu = 1; d_rn = 7; #1;
    nxt(); #1;
    chk("rm_busy", 8'(mdu_busy), 8'd1);
    nxt(); resetn = 0; rs = 7; urs = 1; #1;
    chk("rm_in_busy", 8'(mdu_busy), 8'd0);
    chk("rm_in_wpcir", 8'(wpcir), 8'd1);
    nxt(); resetn = 1; rs = 7; urs = 1; #1;
    chk("rm_after_busy", 8'(mdu_busy), 8'd0);
    chk("rm_after_wpcir", 8'(wpcir), 8'd1);
    chk("rm_after_wb", 8'(mdu_wb), 8'd0);
    nxt(); rs = 7; urs = 1; #1;
    chk("rm_no_wb", 8'(mdu_wb), 8'd0);
    chk("rm_no_fwd", 8'(fwda), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline.
- Generalises the E/M-only forwarding to a W-stage source and a multi-cycle multiply/divide unit (MDU) source.
- Adds a sequential scoreboard for the single outstanding MDU write, with its own stalls.
- Sits beside the decode-stage control unit. That unit supplies decoded use/write flags; this block returns stall, bubble and operand-select signals.

Parameters:
RW, 5, register-address width (register file has 2**RW entries; register 0 is hard-wired zero)
MDU_LAT, 4, cycles from MDU issue (E entry) to MDU result write-back; legal range 2..15

Ports:
clock  in  1  pipeline clock
resetn  in  1  reset, synchronous, active-low
rs  in  RW  D-stage source register A
rt  in  RW  D-stage source register B
urs  in  1  D instruction reads rs
urt  in  1  D instruction reads rt
d_wreg  in  1  D instruction writes a register through the normal pipe
d_mdu  in  1  D instruction is an MDU op (writes d_rn after MDU_LAT cycles)
d_rn  in  RW  D instruction destination
ewreg, em2reg  in  1 each  E-stage write / load flags
ern  in  RW  E-stage destination
mwreg, mm2reg  in  1 each  M-stage write / load flags
mrn  in  RW  M-stage destination
wwreg  in  1  W-stage write flag
wrn  in  RW  W-stage destination
wpcir  out  1  1 = PC and F/D register may advance
bubble  out  1  1 = E register loads a no-op (wreg/wmem/mdu cleared)
fwda  out  3  operand-A select
fwdb  out  3  operand-B select
mdu_busy  out  1  scoreboard holds a pending MDU write
mdu_wb  out  1  one-cycle pulse: MDU result written to mdu_rn this cycle
mdu_rn  out  RW  pending MDU destination

Behaviour:
- Select encoding:
  - 000 register file
  - 001 E ALU
  - 010 M ALU
  - 011 M memory
  - 100 W data
  - 101 MDU result
- Forward priority: E > M > W > MDU (only when mdu_wb=1). Same rule for rt/fwdb.
- Never forward register 0. Stage flags must be 1 for a match. Forwarding outputs are combinational.
- Load-use hazard: ewreg & em2reg & ern!=0 & ((urs & ern==rs) | (urt & ern==rt)).
- RAW-MDU hazard: mdu_busy & ~mdu_wb & mdu_rn!=0 & ((urs & mdu_rn==rs) | (urt & mdu_rn==rt)).
  - In the write-back cycle, forwarding resolves it, so no stall.
- Structural hazard: d_mdu & mdu_busy & ~mdu_wb. A new MDU op may issue in the write-back cycle.
- WAW hazard: (d_wreg | d_mdu) & mdu_busy & ~mdu_wb & d_rn==mdu_rn & d_rn!=0.
- stall = OR of the four hazards. wpcir = ~stall. bubble = stall.
- Scoreboard registers: cnt (4 bits), mdu_rn, busy.
  - Idle (cnt=0): if d_mdu & ~stall, load cnt=MDU_LAT, mdu_rn=d_rn, busy=1 at the next edge.
  - Counting: cnt decrements every cycle, regardless of stall.
  - mdu_wb = (cnt==1). At that edge busy clears, unless a new MDU op is accepted in the same cycle; then it reloads cnt=MDU_LAT and the new mdu_rn.
- MDU op with d_rn=0: it is tracked (occupies the unit) but is never forwarded and raises no RAW/WAW hazard.
- Reset (resetn=0 at a clock edge): cnt=0, busy=0, mdu_rn=0.
  - Outputs while in reset: wpcir=1, bubble=0, fwda=fwdb=000, mdu_busy=0, mdu_wb=0, mdu_rn=0.
  - Reset mid-operation drops the pending MDU write; no mdu_wb is emitted.
- Latency: stall/forwarding act the same cycle (combinational from inputs and state). Scoreboard update takes one cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_* select constants (3-bit)
  - RW default
  - MDU_LAT default
- Natural sub-module: mdu_scoreboard (counter, busy, mdu_rn, mdu_wb generation).
- Top-level keeps the hazard equations and the forwarding priority muxes.

Test Plan:
1. lw r3 in E (ewreg=1, em2reg=1, ern=3); D add with rs=3, urs=1 -> wpcir=0, bubble=1 for exactly 1 cycle. Next cycle M matches -> fwda=011.
2. E ern=5 ALU and W wrn=5 both valid, rs=5 -> fwda=001. Drop E -> fwda=100. rs=0 with ern=0 -> fwda=000.
3. MDU_LAT=4, d_mdu issues to r7 at cycle t:
   - mdu_busy=1 during t+1..t+4; mdu_wb at t+4.
   - D reads r7 during t+1..t+3 -> stalled. At t+4 no stall and fwda=101.
4. Second d_mdu while busy -> stalled until the mdu_wb cycle, then accepted. mdu_busy stays 1 with no gap; mdu_rn updates.
5. D writes r7 (d_wreg) while MDU pending to r7 -> stall until mdu_wb. D writes r8 -> no stall.
6. resetn=0 at cycle t+2 of a pending MDU op -> mdu_busy=0, no mdu_wb pulse, wpcir=1 on the following cycle.
